div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
- Produces div_stallE for the hazard unit, which freezes E and stalls D/F while a division runs.
- Final quotient and remainder go to the HI/LO write path (LO=quotient, HI=remainder) alongside the E-stage result.

Parameters:
WIDTH, 32, operand width in bits; iteration count equals WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
startE  input  1  decoded DIV/DIVU valid in E; held high by the pipeline while E is frozen.
signedE  input  1  1=DIV (signed), 0=DIVU.
srcaE  input  WIDTH  dividend (rs).
srcbE  input  WIDTH  divisor (rt).
annulE  input  1  cancel the in-flight or requested divide (flush/exception).
div_stallE  output  1  stall request to the hazard unit.
div_readyE  output  1  one-cycle pulse: result valid.
hi_divE  output  WIDTH  remainder.
lo_divE  output  WIDTH  quotient.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Async reset to IDLE; counter=0; hi_divE=0; lo_divE=0; div_readyE=0; div_stallE=0.
- div_stallE is combinational: (IDLE & startE & ~annulE) | BUSY. It is high in the same cycle the divide is requested, so E never advances before the result exists.
- IDLE -> BUSY when startE & ~annulE.
  - On that edge, latch |srcaE| and |srcbE| (magnitudes when signedE, raw values otherwise).
  - Also latch sign_q = signedE & (a[31]^b[31]) and sign_r = signedE & a[31].
  - Clear the partial remainder; counter=0.
- BUSY: one restoring step per cycle.
  - Shift {rem,quo} left by 1 and trial-subtract the divisor from rem (WIDTH+1 bit subtract).
  - If the result is non-negative, keep it and set the quotient LSB to 1.
  - counter++. After the step with counter==WIDTH-1, go to DONE.
- DONE:
  - Apply sign correction: negate the quotient if sign_q, negate the remainder if sign_r.
  - Register the results into lo_divE/hi_divE on entry, so outputs are valid in DONE.
  - div_readyE=1 and div_stallE=0 in DONE. E advances at the end of this cycle.
  - DONE -> IDLE unconditionally. startE still high in DONE is ignored.
- Latency: the request cycle plus WIDTH BUSY cycles gives 33 stall cycles (WIDTH=32). div_readyE rises in cycle 34.
- hi_divE/lo_divE hold their value until the next DONE.
- Divide by zero (srcbE==0): no trap. Result is lo=all ones (magnitude path), hi=dividend. Signed divide applies the same sign correction.
- Overflow 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0. No special case; this falls out of magnitude arithmetic.
- annulE in BUSY: abort to IDLE next edge; div_stallE drops next cycle; outputs unchanged; no div_readyE pulse.
- annulE in IDLE with startE: no start, no stall.
- annulE in DONE: div_readyE still pulses; the pipeline discards the result.
- Reset mid-operation: immediate return to IDLE, outputs zeroed.
- Back-to-back: a new startE is accepted in the IDLE cycle following DONE.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if the divisor is 0, or |dividend| < |divisor|, skip BUSY and go IDLE -> DONE in one cycle.
  - Result is q=0, r=dividend; divide-by-zero still gives the all-ones quotient.
  - div_stallE is high for only the request cycle.
- Undefined: every divide takes the full WIDTH iterations.

Test Plan:
- DIVU 100/7: startE held -> div_stallE high 33 cycles, div_readyE pulse, lo=14, hi=2.
- DIV -7/2 (0xFFFFFFF9/2): lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2: lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0. DIVU 5/0: lo=0xFFFFFFFF, hi=5; 33-cycle stall (1 cycle with DIV_EARLY_EXIT_EN).
- annulE at BUSY cycle 10: stall drops next cycle, no div_readyE, hi/lo keep previous values. rst pulsed at BUSY cycle 5: stall=0 immediately, hi=lo=0.
- Back-to-back DIVU 9/4 then 20/3: second stall begins the cycle after the first DONE. Results lo=2/hi=1, then lo=6/hi=2. startE held in DONE does not restart.

Source files
------------

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Optional: define DIV_EARLY_EXIT_EN to skip iterations when divisor==0 or |dividend|<|divisor|.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             annulE,
  output logic             div_stallE,
  output logic             div_readyE,
  output logic [WIDTH-1:0] hi_divE,
  output logic [WIDTH-1:0] lo_divE
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [CNT_W-1:0]   counter;
  logic               signQ;
  logic               signR;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic               signQIn;
  logic [WIDTH:0]     remShift;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   quoNext;
  logic               startOk;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    absA     = srcaE;
    absB     = srcbE;
    signQIn  = signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
    if (signedE && srcaE[WIDTH-1]) absA = -srcaE;
    if (signedE && srcbE[WIDTH-1]) absB = -srcbE;

    // rem < divisor always holds, so the WIDTH+1 bit difference's MSB is a true sign bit.
    remShift = {rem, quo[WIDTH-1]};
    trial    = remShift - {1'b0, divisor};
    if (trial[WIDTH]) begin
      remNext = remShift[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], 1'b0};
    end else begin
      remNext = trial[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], 1'b1};
    end
  end

  assign startOk    = (state == IDLE) && startE && !annulE;
  assign div_stallE = startOk || (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      divisor    <= '0;
      rem        <= '0;
      quo        <= '0;
      signQ      <= 1'b0;
      signR      <= 1'b0;
      hi_divE    <= '0;
      lo_divE    <= '0;
      div_readyE <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      div_readyE <= 1'b0;
      case (state)
        IDLE: begin
          if (startOk) begin
            divisor <= absB;
            quo     <= absA;
            rem     <= '0;
            counter <= '0;
            signQ   <= signQIn;
            signR   <= signedE & srcaE[WIDTH-1];
`ifdef DIV_EARLY_EXIT_EN
            if ((absB == '0) || (absA < absB)) begin
              state      <= DONE;
              div_readyE <= 1'b1;
              hi_divE    <= srcaE;
              if (absB == '0)
                lo_divE <= signQIn ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
              else
                lo_divE <= '0;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (annulE) begin
            state <= IDLE;
          end else begin
            rem     <= remNext;
            quo     <= quoNext;
            counter <= counter + 1'b1;
            if (counter == CNT_W'(WIDTH - 1)) begin
              state      <= DONE;
              div_readyE <= 1'b1;
              lo_divE    <= signQ ? -quoNext : quoNext;
              hi_divE    <= signR ? -remNext : remNext;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: latency, signed/unsigned results, annul and reset.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic        signedE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        annulE;
  logic        div_stallE;
  logic        div_readyE;
  logic [31:0] hi_divE;
  logic [31:0] lo_divE;

  int passCnt  = 0;
  int totalCnt = 0;

`ifdef DIV_EARLY_EXIT_EN
  localparam int ZERO_DIV_STALLS = 1;
`else
  localparam int ZERO_DIV_STALLS = 33;
`endif

  div_iter dut (
    .clk        (clk),
    .rst        (rst),
    .startE     (startE),
    .signedE    (signedE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .annulE     (annulE),
    .div_stallE (div_stallE),
    .div_readyE (div_readyE),
    .hi_divE    (hi_divE),
    .lo_divE    (lo_divE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Issues a divide, holds startE until the ready pulse, and checks the DONE cycle.
  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expLo, input logic [31:0] expHi, input int expStalls);
    int cyc;
    int stalls;
    @(negedge clk);
    signedE = sgn;
    srcaE   = a;
    srcbE   = b;
    startE  = 1'b1;
    #1;
    check({tag, ".stallStart"}, 32'(div_stallE), 32'd1);
    cyc    = 0;
    stalls = 0;
    while (!div_readyE && cyc < 100) begin
      if (div_stallE) stalls++;
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, ".ready"}, 32'(div_readyE), 32'd1);
    check({tag, ".stallInDone"}, 32'(div_stallE), 32'd0);
    check({tag, ".lo"}, lo_divE, expLo);
    check({tag, ".hi"}, hi_divE, expHi);
    check({tag, ".stalls"}, 32'(stalls), 32'(expStalls));
  endtask

  // startE is still high in DONE; a restart would show up as a stall here.
  task automatic idleCheck(input string tag);
    @(negedge clk);
    startE = 1'b0;
    #1;
    check({tag, ".noRestart"}, 32'(div_stallE), 32'd0);
    check({tag, ".readyDrop"}, 32'(div_readyE), 32'd0);
  endtask

  initial begin
    int pulses;
    rst     = 1'b1;
    startE  = 1'b0;
    signedE = 1'b0;
    srcaE   = '0;
    srcbE   = '0;
    annulE  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.stall", 32'(div_stallE), 32'd0);
    check("reset.ready", 32'(div_readyE), 32'd0);
    check("reset.lo", lo_divE, 32'd0);
    check("reset.hi", hi_divE, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runDiv("divu100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    idleCheck("divu100_7");
    runDiv("divNeg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    idleCheck("divNeg7_2");
    runDiv("div7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    idleCheck("div7_neg2");
    runDiv("divOvf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    idleCheck("divOvf");
    runDiv("divu5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZERO_DIV_STALLS);
    idleCheck("divu5_0");

    // Back-to-back: the second request lands in the IDLE cycle right after the first DONE.
    runDiv("b2b9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33);
    runDiv("b2b20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33);
    idleCheck("b2b20_3");

    // Annul alongside a request in IDLE: nothing starts.
    @(negedge clk);
    srcaE   = 32'd100;
    srcbE   = 32'd7;
    startE  = 1'b1;
    annulE  = 1'b1;
    #1;
    check("annulIdle.stall", 32'(div_stallE), 32'd0);
    @(negedge clk);
    startE = 1'b0;
    annulE = 1'b0;
    #1;
    check("annulIdle.notStarted", 32'(div_stallE), 32'd0);

    // Annul at BUSY cycle 10: stall drops next cycle, results untouched, no ready.
    @(negedge clk);
    srcaE  = 32'd1000;
    srcbE  = 32'd3;
    startE = 1'b1;
    repeat (10) @(negedge clk);
    annulE = 1'b1;
    startE = 1'b0;
    #1;
    check("annulBusy.stallBefore", 32'(div_stallE), 32'd1);
    @(negedge clk);
    annulE = 1'b0;
    #1;
    check("annulBusy.stallAfter", 32'(div_stallE), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (div_readyE) pulses++;
      @(negedge clk);
      #1;
    end
    check("annulBusy.noReady", 32'(pulses), 32'd0);
    check("annulBusy.lo", lo_divE, 32'd6);
    check("annulBusy.hi", hi_divE, 32'd2);

    // Reset at BUSY cycle 5.
    @(negedge clk);
    srcaE  = 32'd1000;
    srcbE  = 32'd3;
    startE = 1'b1;
    repeat (5) @(negedge clk);
    rst    = 1'b1;
    startE = 1'b0;
    #1;
    check("rstBusy.stall", 32'(div_stallE), 32'd0);
    check("rstBusy.ready", 32'(div_readyE), 32'd0);
    check("rstBusy.lo", lo_divE, 32'd0);
    check("rstBusy.hi", hi_divE, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runDiv("afterRst1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);
    idleCheck("afterRst1000_3");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
